alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle controller that sequences the 20-bit ALU for one instruction at a time.
- Accepts a decoded op from the front-end with a valid/ready handshake and reads two operands from the register file.
- Presents the operands and the 13-bit instruction code to the ALU, then captures the registered ALU result one clock later.
- Writes the result back to the register file and posts a 13-bit flag word to the status register (SX).

Parameters:
- DATA_W, 20, datapath width.
- INSTR_W, 13, ALU instruction-code width.
- FLAG_W, 13, SX flag-word width.
- RADDR_W, 4, register-file address width.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
op_valid  in  1  front-end op available
op_ready  out  1  sequencer can accept op
op_code  in  INSTR_W  ALU instruction code
op_rs_a  in  RADDR_W  source A register
op_rs_b  in  RADDR_W  source B register
op_rd  in  RADDR_W  destination register
rf_ra_addr  out  RADDR_W  RF read port A address
rf_rb_addr  out  RADDR_W  RF read port B address
rf_ra_data  in  DATA_W  RF read data A (combinational)
rf_rb_data  in  DATA_W  RF read data B (combinational)
alu_instr  out  INSTR_W  code to ALU
alu_a  out  DATA_W  ALU operand A
alu_b  out  DATA_W  ALU operand B
alu_cin  out  1  ALU carry-in
alu_result  in  DATA_W  ALU result (registered in ALU)
alu_carry  in  1  ALU carry_out
alu_flags  in  FLAG_W  ALU compare flags
rf_we  out  1  RF write enable (1-cycle pulse)
rf_wa  out  RADDR_W  RF write address
rf_wd  out  DATA_W  RF write data
sx_we  out  1  SX update pulse
sx_flags  out  FLAG_W  flag word to SX
err  out  1  illegal-opcode pulse
busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values: state = IDLE; all outputs 0 except op_ready = 1; internal carry_q = 0; latched op fields = 0.
- FSM states: IDLE -> READ -> EXEC -> WAIT -> WB -> IDLE.
  - IDLE: op_ready = 1. When op_valid & op_ready, latch op_code/rs_a/rs_b/rd and go to READ.
  - READ: rf_ra_addr = rs_a, rf_rb_addr = rs_b. Latch rf_ra_data/rf_rb_data at the clock edge.
  - EXEC: alu_instr, alu_a, alu_b held stable and alu_cin = carry_q. The ALU samples at the end of this cycle.
  - WAIT: capture alu_result, alu_carry and alu_flags.
  - WB: drive the rf_we/sx_we/err pulses (see below). Next state is IDLE.
- Latency and throughput:
  - Handshake edge to rf_we high = 4 clocks.
  - op_ready deasserted for READ..WB, giving one op per 5 clocks.
- alu_instr rule: equals 0 outside EXEC/WAIT.
- Op classes (by op_code):
  - Logic/shift/arith: 0A7, 0D1, 0BC, 0E6, 0FB, 110, 125, 13A, 164, 179, 18E, 1A3, 1B8, 1CD. WB asserts rf_we and sx_we; rf_wa = rd, rf_wd = captured result.
  - Compare: 1E2, 1F7, 20C, 221, 236. WB asserts sx_we only; rf_we = 0.
  - Any other code is illegal: WB asserts err only; no rf_we, no sx_we.
- Flag word (sx_flags):
  - bit0 ZE = (result == 0) for non-compare ops; alu_flags[0] for compare ops.
  - bit1 N = result[19] for non-compare ops; alu_flags[1] for compare ops.
  - bit4 F = carry_q after update.
  - bit9 S = (rs_a == rs_b).
  - All other bits 0.
- Carry: carry_q is updated only by ADDC (1A3) and SUBC (1CD), taking alu_carry in WB. All other ops leave it unchanged.
- Single-operand ops: NOT/INC/DEC still read both ports; alu_b is don't-care.
- op_valid while busy: ignored; the front-end must hold op_valid until accepted.
- Reset mid-operation: abort immediately to IDLE. No rf_we/sx_we/err is issued for the aborted op, and carry_q clears.

Optional Feature:
- Macro ALU_SEQ_SHAMT_WRAP_EN.
- Defined: for SHFTR/SHFTL/ROTR/ROTL (0FB, 110, 125, 13A), alu_b = latched B mod 20 (value 0..19). Shift/rotate amounts therefore never reach or exceed the word width.
- Undefined: alu_b is the raw latched B for all ops.

Test Plan:
- ADD: R1 = 0x00005, R2 = 0x00003, rd = R3. Bench ALU returns 0x00008. Required: rf_we pulse exactly 4 clocks after the handshake, rf_wa = 3, rf_wd = 0x00008, sx_flags = 0x000 with ZE = 0, N = 0, S = 0; op_ready low for 4 cycles.
- ADDC chain: first ADDC with ALU carry_out = 1, then a second ADDC. Required: second op's alu_cin = 1 during EXEC and sx_flags bit4 = 1. A following ADD must leave carry_q = 1.
- EQ (1E2) with rs_a = rs_b = R4 and alu_flags = 0x001. Required: sx_we = 1, rf_we = 0, sx_flags = 0x201 (ZE, S).
- Illegal code 0x14F. Required: err pulses for one cycle in WB, rf_we = 0, sx_we = 0, back in IDLE on the next clock.
- rst_n low during EXEC of a SUB. Required: next clock state = IDLE, op_ready = 1, busy = 0, no rf_we ever issued, carry_q = 0.
- Shift amount: SHFTL with B = 23. With ALU_SEQ_SHAMT_WRAP_EN, alu_b = 3 in EXEC; without it, alu_b = 23.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller that sequences one ALU instruction at a time.
//   Front-end : op_valid/op_ready handshake carrying op_code, op_rs_a, op_rs_b, op_rd.
//   Reg file  : rf_ra_addr/rf_rb_addr -> rf_ra_data/rf_rb_data (combinational reads),
//               rf_we/rf_wa/rf_wd single-cycle write-back.
//   ALU       : alu_instr/alu_a/alu_b/alu_cin out; alu_result/alu_carry/alu_flags in,
//               registered inside the ALU (result valid one clock after EXEC).
//   Status    : sx_we/sx_flags flag-word update, err illegal-opcode pulse, busy.
// Sequence: IDLE -> READ -> EXEC -> WAIT -> WB -> IDLE (one op per 5 clocks).
// Optional feature macro: ALU_SEQ_SHAMT_WRAP_EN (shift/rotate amount taken mod DATA_W).
module alu_sequencer #(
    parameter int unsigned DATA_W  = 20,
    parameter int unsigned INSTR_W = 13,
    parameter int unsigned FLAG_W  = 13,
    parameter int unsigned RADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [INSTR_W-1:0] op_code,
    input  logic [RADDR_W-1:0] op_rs_a,
    input  logic [RADDR_W-1:0] op_rs_b,
    input  logic [RADDR_W-1:0] op_rd,
    output logic [RADDR_W-1:0] rf_ra_addr,
    output logic [RADDR_W-1:0] rf_rb_addr,
    input  logic [DATA_W-1:0]  rf_ra_data,
    input  logic [DATA_W-1:0]  rf_rb_data,
    output logic [INSTR_W-1:0] alu_instr,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic               alu_cin,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_carry,
    input  logic [FLAG_W-1:0]  alu_flags,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0]  rf_wd,
    output logic               sx_we,
    output logic [FLAG_W-1:0]  sx_flags,
    output logic               err,
    output logic               busy
);

    localparam logic [INSTR_W-1:0] OP_ADDC = INSTR_W'('h1A3);
    localparam logic [INSTR_W-1:0] OP_SUBC = INSTR_W'('h1CD);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WAIT = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [INSTR_W-1:0] code_q;
    logic [RADDR_W-1:0] rs_a_q, rs_b_q, rd_q;
    logic [DATA_W-1:0]  a_q, b_q, res_q, b_eff;
    logic [1:0]         res_flags_q;
    logic               res_carry_q, carry_q, carry_next;
    logic               is_arith, is_cmp;
    logic [FLAG_W-1:0]  flags_c;

    // Only the ZE/N compare bits of the ALU flag bus are consumed.
    logic unused_flags;
    assign unused_flags = ^alu_flags[FLAG_W-1:2];

    // Opcode classification of the latched op.
    assign is_arith = code_q inside {INSTR_W'('h0A7), INSTR_W'('h0D1), INSTR_W'('h0BC),
                                     INSTR_W'('h0E6), INSTR_W'('h0FB), INSTR_W'('h110),
                                     INSTR_W'('h125), INSTR_W'('h13A), INSTR_W'('h164),
                                     INSTR_W'('h179), INSTR_W'('h18E), INSTR_W'('h1A3),
                                     INSTR_W'('h1B8), INSTR_W'('h1CD)};
    assign is_cmp   = code_q inside {INSTR_W'('h1E2), INSTR_W'('h1F7), INSTR_W'('h20C),
                                     INSTR_W'('h221), INSTR_W'('h236)};

    // Carry as it stands after this op's write-back; F reports the updated value.
    assign carry_next = (code_q == OP_ADDC || code_q == OP_SUBC) ? res_carry_q : carry_q;

`ifdef ALU_SEQ_SHAMT_WRAP_EN
    logic is_shift;
    assign is_shift = code_q inside {INSTR_W'('h0FB), INSTR_W'('h110),
                                     INSTR_W'('h125), INSTR_W'('h13A)};
    // Keep shift/rotate amounts strictly below the word width.
    assign b_eff = is_shift ? DATA_W'(b_q % DATA_W'(DATA_W)) : b_q;
`else
    assign b_eff = b_q;
`endif

    // Flag word for the status register.
    always_comb begin
        flags_c = '0;
        if (is_cmp) begin
            flags_c[0] = res_flags_q[0];
            flags_c[1] = res_flags_q[1];
        end else begin
            flags_c[0] = (res_q == '0);
            flags_c[1] = res_q[DATA_W-1];
        end
        flags_c[4] = carry_next;
        flags_c[9] = (rs_a_q == rs_b_q);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (op_valid) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WAIT;
            S_WAIT:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode; every value comes from a register.
    always_comb begin
        op_ready   = 1'b0;
        busy       = 1'b1;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_instr  = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_cin    = 1'b0;
        rf_we      = 1'b0;
        rf_wa      = '0;
        rf_wd      = '0;
        sx_we      = 1'b0;
        sx_flags   = '0;
        err        = 1'b0;
        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                busy     = 1'b0;
            end
            S_READ: begin
                rf_ra_addr = rs_a_q;
                rf_rb_addr = rs_b_q;
            end
            S_EXEC, S_WAIT: begin
                alu_instr = code_q;
                alu_a     = a_q;
                alu_b     = b_eff;
                alu_cin   = carry_q;
            end
            S_WB: begin
                if (is_arith) begin
                    rf_we    = 1'b1;
                    rf_wa    = rd_q;
                    rf_wd    = res_q;
                    sx_we    = 1'b1;
                    sx_flags = flags_c;
                end else if (is_cmp) begin
                    sx_we    = 1'b1;
                    sx_flags = flags_c;
                end else begin
                    err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Op latch, operand latch, result capture and carry update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q      <= '0;
            rs_a_q      <= '0;
            rs_b_q      <= '0;
            rd_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            res_flags_q <= '0;
            res_carry_q <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (op_valid) begin
                    code_q <= op_code;
                    rs_a_q <= op_rs_a;
                    rs_b_q <= op_rs_b;
                    rd_q   <= op_rd;
                end
                S_READ: begin
                    a_q <= rf_ra_data;
                    b_q <= rf_rb_data;
                end
                S_WAIT: begin
                    res_q       <= alu_result;
                    res_carry_q <= alu_carry;
                    res_flags_q <= alu_flags[1:0];
                end
                S_WB:    carry_q <= carry_next;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a register file and a registered ALU are modelled
// around the DUT; a reference model predicts each op's write-back and flag word.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [12:0] op_code = '0;
    logic [3:0]  op_rs_a = '0, op_rs_b = '0, op_rd = '0;
    logic [3:0]  rf_ra_addr, rf_rb_addr;
    logic [19:0] rf_ra_data, rf_rb_data;
    logic [12:0] alu_instr;
    logic [19:0] alu_a, alu_b;
    logic        alu_cin;
    logic [19:0] alu_result;
    logic        alu_carry;
    logic [12:0] alu_flags;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [19:0] rf_wd;
    logic        sx_we;
    logic [12:0] sx_flags;
    logic        err;
    logic        busy;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_rs_a(op_rs_a), .op_rs_b(op_rs_b), .op_rd(op_rd),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
        .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_flags(alu_flags),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .sx_we(sx_we), .sx_flags(sx_flags), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Environment register file: combinational reads, writes from the DUT or a preload.
    logic [19:0] rf [16];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [19:0] pre_data = '0;
    assign rf_ra_data = rf[rf_ra_addr];
    assign rf_rb_data = rf[rf_rb_addr];
    always @(posedge clk) begin
        if (rf_we)       rf[rf_wa]    <= rf_wd;
        else if (pre_we) rf[pre_addr] <= pre_data;
    end

    // Bench ALU: sum with carry, compare flags {junk, a<b, a==b}; registered outputs.
    function automatic logic [20:0] alu_sum(input logic [19:0] a, input logic [19:0] b,
                                            input logic cin);
        return {1'b0, a} + {1'b0, b} + 21'(cin);
    endfunction
    function automatic logic [12:0] alu_flg(input logic [19:0] a, input logic [19:0] b);
        return {a[12:2] ^ b[12:2], a < b, a == b};
    endfunction
    always @(posedge clk) begin
        {alu_carry, alu_result} <= alu_sum(alu_a, alu_b, alu_cin);
        alu_flags               <= alu_flg(alu_a, alu_b);
    end

    // Reference model state.
    logic [19:0] mrf [16];
    logic        mcarry = 1'b0;

    typedef struct {
        logic        we;
        logic        sxw;
        logic        er;
        logic [3:0]  wa;
        logic [19:0] wd;
        logic [12:0] fl;
        int          hs;
    } exp_t;
    exp_t exp_q[$];

    function automatic bit is_arith(input logic [12:0] c);
        return c inside {13'h0A7, 13'h0D1, 13'h0BC, 13'h0E6, 13'h0FB, 13'h110, 13'h125,
                         13'h13A, 13'h164, 13'h179, 13'h18E, 13'h1A3, 13'h1B8, 13'h1CD};
    endfunction
    function automatic bit is_cmp(input logic [12:0] c);
        return c inside {13'h1E2, 13'h1F7, 13'h20C, 13'h221, 13'h236};
    endfunction

    // Monitor: every output pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (rst_n && (rf_we || sx_we || err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {61'd0, rf_we, sx_we, err}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rf_we", 64'(rf_we), 64'(e.we));
                chk("sx_we", 64'(sx_we), 64'(e.sxw));
                chk("err", 64'(err), 64'(e.er));
                chk("wb_edge_after_hs", 64'(cyc + 1 - e.hs), 64'd4);
                if (e.we) begin
                    chk("rf_wa", 64'(rf_wa), 64'(e.wa));
                    chk("rf_wd", 64'(rf_wd), 64'(e.wd));
                end
                if (e.sxw) chk("sx_flags", 64'(sx_flags), 64'(e.fl));
            end
        end
    end

    task automatic preload(input logic [3:0] addr, input logic [19:0] data);
        pre_addr = addr;
        pre_data = data;
        pre_we   = 1'b1;
        mrf[addr] = data;
        @(posedge clk);
        #1 pre_we = 1'b0;
        @(negedge clk);
    endtask

    // Issue one op, predict its outcome, and check the READ/EXEC phase and op_ready timing.
    task automatic issue(input logic [12:0] code, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rd, input bit abort);
        exp_t        e;
        logic [19:0] a, b, beff;
        logic [20:0] sum;
        logic [12:0] af;
        logic        newc;
        int          guard = 0;
        while (op_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("op_ready_timeout", 64'(op_ready), 64'd1);
        a    = mrf[ra];
        b    = mrf[rb];
        beff = b;
`ifdef ALU_SEQ_SHAMT_WRAP_EN
        if (code inside {13'h0FB, 13'h110, 13'h125, 13'h13A}) beff = b % 20;
`endif
        sum  = alu_sum(a, beff, mcarry);
        af   = alu_flg(a, beff);
        newc = (code == 13'h1A3 || code == 13'h1CD) ? sum[20] : mcarry;
        e.we  = is_arith(code);
        e.sxw = is_arith(code) || is_cmp(code);
        e.er  = !e.sxw;
        e.wa  = rd;
        e.wd  = sum[19:0];
        e.fl  = '0;
        if (is_cmp(code)) e.fl[1:0] = af[1:0];
        else begin
            e.fl[0] = (sum[19:0] == 20'd0);
            e.fl[1] = sum[19];
        end
        e.fl[4] = newc;
        e.fl[9] = (ra == rb);
        op_code = code; op_rs_a = ra; op_rs_b = rb; op_rd = rd;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        e.hs = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        chk("read_ra_addr", 64'(rf_ra_addr), 64'(ra));
        chk("read_rb_addr", 64'(rf_rb_addr), 64'(rb));
        chk("read_op_ready", 64'(op_ready), 64'd0);
        @(negedge clk);
        chk("exec_instr", 64'(alu_instr), 64'(code));
        chk("exec_a", 64'(alu_a), 64'(a));
        chk("exec_b", 64'(alu_b), 64'(beff));
        chk("exec_cin", 64'(alu_cin), 64'(mcarry));
        chk("exec_busy", 64'(busy), 64'd1);
        if (abort) begin
            rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
            chk("abort_op_ready", 64'(op_ready), 64'd1);
            chk("abort_busy", 64'(busy), 64'd0);
            void'(exp_q.pop_back());
            mcarry = 1'b0;
            repeat (5) @(negedge clk);
            return;
        end
        @(negedge clk);
        chk("wait_op_ready", 64'(op_ready), 64'd0);
        @(negedge clk);
        chk("wb_op_ready", 64'(op_ready), 64'd0);
        @(negedge clk);
        chk("idle_op_ready", 64'(op_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_alu_instr", 64'(alu_instr), 64'd0);
        mcarry = newc;
        if (e.we) mrf[rd] = e.wd;
    endtask

    logic [12:0] legal [19] = '{13'h0A7, 13'h0D1, 13'h0BC, 13'h0E6, 13'h0FB, 13'h110,
                               13'h125, 13'h13A, 13'h164, 13'h179, 13'h18E, 13'h1A3,
                               13'h1B8, 13'h1CD, 13'h1E2, 13'h1F7, 13'h20C, 13'h221,
                               13'h236};

    initial begin
        logic [12:0] code;
        int          guard;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_op_ready", 64'(op_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pulses", {61'd0, rf_we, sx_we, err}, 64'd0);
        chk("rst_alu_instr", 64'(alu_instr), 64'd0);
        chk("rst_alu_cin", 64'(alu_cin), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) preload(4'(i), 20'($urandom));

        preload(4'd1, 20'h00005);
        preload(4'd2, 20'h00003);
        issue(13'h18E, 4'd1, 4'd2, 4'd3, 1'b0);           // ADD -> 8, flags 0
        issue(13'h1E2, 4'd4, 4'd4, 4'd0, 1'b0);           // EQ same reg -> 0x201
        preload(4'd5, 20'hFFFFF);
        preload(4'd6, 20'h00001);
        issue(13'h1A3, 4'd5, 4'd6, 4'd7, 1'b0);           // ADDC, carry out 1
        issue(13'h1A3, 4'd1, 4'd2, 4'd8, 1'b0);           // ADDC sees cin = 1
        issue(13'h18E, 4'd1, 4'd2, 4'd9, 1'b0);           // ADD keeps carry
        issue(13'h14F, 4'd1, 4'd2, 4'd9, 1'b0);           // illegal
        issue(13'h1B8, 4'd1, 4'd2, 4'd11, 1'b1);          // SUB aborted by reset
        issue(13'h18E, 4'd1, 4'd2, 4'd12, 1'b0);          // carry cleared
        preload(4'd10, 20'd23);
        issue(13'h110, 4'd1, 4'd10, 4'd13, 1'b0);         // SHFTL with B = 23

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                code = 13'($urandom);
                while (is_arith(code) || is_cmp(code)) code = 13'($urandom);
            end else begin
                code = legal[$urandom_range(0, 18)];
            end
            issue(code, 4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
